// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: opcodes, the reset NOP and the
// fetch state encoding.
package riscv_pkg;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_S    = 7'b0100011;
    localparam logic [6:0] OPC_L    = 7'b0000011;
    localparam logic [6:0] OPC_B    = 7'b1100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_HALT = 7'b1110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_STOP  = 2'd3
    } fetch_state_t;

    // Word-aligned targets only; JALR clears bit 0 before this is checked.
    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: halt > JALR > JAL/branch > sequential, plus the
// misaligned-target flag (never raised when halt wins).
module next_pc_calc
    import riscv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic        branch,
    input  logic        jal_flag,
    input  logic        jalr_flag,
    input  logic        halt,
    output logic [31:0] target,
    output logic        halt_sel,
    output logic        misaligned
);

    logic [31:0] jalr_sum_s;
    logic [31:0] rel_sum_s;
    logic [31:0] seq_sum_s;

    assign jalr_sum_s = rs1_data + imm;
    assign rel_sum_s  = pc + imm;
    assign seq_sum_s  = pc + 32'd4;

    // Priority mux over the candidate targets.
    always_comb begin
        target     = seq_sum_s;
        halt_sel   = halt;
        misaligned = 1'b0;
        if (halt) begin
            target = pc;
        end else if (jalr_flag) begin
            target = jalr_sum_s & 32'hFFFF_FFFE;
        end else if (jal_flag || branch) begin
            target = rel_sum_s;
        end else begin
            target = seq_sum_s;
        end
        if (!halt) begin
            misaligned = !is_aligned(target);
        end else begin
            misaligned = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC stage: req/ack fetch, one-cycle EXEC strobe,
// next-PC update and sticky halt/trap until reset.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch,
    input  logic        jal_flag,
    input  logic        jalr_flag,
    input  logic        halt,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        trap
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic         req_q, req_d;
    logic         halted_q, halted_d;
    logic         trap_q, trap_d;

    logic [31:0]  target_s;
    logic         halt_sel_s;
    logic         misaligned_s;

    next_pc_calc u_next_pc (
        .pc         (pc_q),
        .imm        (imm),
        .rs1_data   (rs1_data),
        .branch     (branch),
        .jal_flag   (jal_flag),
        .jalr_flag  (jalr_flag),
        .halt       (halt),
        .target     (target_s),
        .halt_sel   (halt_sel_s),
        .misaligned (misaligned_s)
    );

    // State machine; req and valid are registered from the next state.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = 1'b0;
        req_d    = 1'b0;
        halted_d = halted_q;
        trap_d   = trap_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = ST_EXEC;
                end else begin
                    req_d = 1'b1;
                end
            end
            ST_EXEC: begin
                if (halt_sel_s) begin
                    halted_d = 1'b1;
                    state_d  = ST_STOP;
                end else if (misaligned_s) begin
                    trap_d  = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    pc_d    = target_s;
                    req_d   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_STOP: begin
                state_d = ST_STOP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
            req_q    <= 1'b0;
            halted_q <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            req_q    <= req_d;
            halted_q <= halted_d;
            trap_q   <= trap_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign halted      = halted_q;
    assign trap        = trap_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a delay-programmable
// instruction memory responder.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hCAFE_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch = 1'b0, jal_flag = 1'b0, jalr_flag = 1'b0, halt = 1'b0;
    logic [31:0] imm = 32'd0, rs1_data = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc, pc_plus4;
    logic        halted, trap;

    int checks = 0;
    int errors = 0;
    int ack_delay = 0;
    int req_cycles = 0;
    logic ack_force = 1'b0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .branch     (branch),
        .jal_flag   (jal_flag),
        .jalr_flag  (jalr_flag),
        .halt       (halt),
        .imm        (imm),
        .rs1_data   (rs1_data),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .halted     (halted),
        .trap       (trap)
    );

    always #5 clk = ~clk;

    // Memory: acks after ack_delay wait cycles; data is addr ^ KEY.
    always @(negedge clk) begin
        imem_ack   = (imem_req && (req_cycles == ack_delay)) || ack_force;
        imem_rdata = imem_addr ^ KEY;
        if (imem_req) req_cycles = req_cycles + 1;
        else          req_cycles = 0;
    end

    typedef struct {
        logic        rst_before;
        logic        br, jal, jalr, hlt;
        logic [31:0] imm, rs1, pc, nxt;
        logic        ehalt, etrap;
        int          dly;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_ctl(input logic b, input logic j, input logic jr, input logic h,
                           input logic [31:0] im, input logic [31:0] r1);
        branch = b; jal_flag = j; jalr_flag = jr; halt = h; imm = im; rs1_data = r1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        rst = 1'b0;
    endtask

    // Wait for the EXEC strobe, counting FETCH cycles and checking the held address.
    task automatic wait_exec(input string tag, input logic [31:0] exp_pc, input int exp_req);
        int  reqc = 0;
        bit  found = 1'b0;
        bit  addr_bad = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                found = 1'b1;
            end else if (imem_req) begin
                reqc++;
                if (imem_addr !== exp_pc) addr_bad = 1'b1;
                set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0);
            end
        end
        chk({tag, "_valid_seen"}, {31'd0, found}, 32'd1);
        chk({tag, "_req_cycles"}, reqc, exp_req);
        chk({tag, "_addr_held"}, {31'd0, addr_bad}, 32'd0);
        chk({tag, "_pc"}, pc, exp_pc);
        chk({tag, "_instr"}, instr, exp_pc ^ KEY);
        chk({tag, "_pc_plus4"}, pc_plus4, exp_pc + 32'd4);
    endtask

    initial begin
        //          rst   br    jal   jalr  hlt   imm            rs1           pc             nxt            eh    et    dly
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,        32'h0,         32'h4,         1'b0, 1'b0, 0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,        32'h4,         32'h8,         1'b0, 1'b0, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8,         32'h0,        32'h8,         32'h10,        1'b0, 1'b0, 0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,        32'h10,        32'h14,        1'b0, 1'b0, 3};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hC,         32'h0,        32'h14,        32'h20,        1'b0, 1'b0, 0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0,        32'h20,        32'h18,        1'b0, 1'b0, 0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4,         32'h101,      32'h18,        32'h104,       1'b0, 1'b0, 0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1,         32'h3F,       32'h104,       32'h40,        1'b0, 1'b0, 0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8,         32'h0,        32'h40,        32'h40,        1'b1, 1'b0, 0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,        32'h0,         32'hFFFF_FFFC, 1'b0, 1'b0, 1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,        32'hFFFF_FFFC, 32'h0,         1'b0, 1'b0, 0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2,         32'h0,        32'h0,         32'h0,         1'b0, 1'b1, 0};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            if (vecs[i].rst_before) do_reset();
            ack_delay = vecs[i].dly;
            wait_exec(tag, vecs[i].pc, vecs[i].dly + 1);
            set_ctl(vecs[i].br, vecs[i].jal, vecs[i].jalr, vecs[i].hlt, vecs[i].imm, vecs[i].rs1);
            @(posedge clk); #1;
            set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            chk({tag, "_valid_drop"}, {31'd0, instr_valid}, 32'd0);
            chk({tag, "_halted"}, {31'd0, halted}, {31'd0, vecs[i].ehalt});
            chk({tag, "_trap"}, {31'd0, trap}, {31'd0, vecs[i].etrap});
            if (vecs[i].ehalt || vecs[i].etrap) begin
                chk({tag, "_pc_frozen"}, pc, vecs[i].pc);
                // Terminal: no requests and no strobes even with controls toggling.
                set_ctl(1'b1, 1'b1, 1'b1, 1'b0, 32'h4, 32'h8);
                for (int c = 0; c < 20; c++) begin
                    @(posedge clk); #1;
                    chk({tag, "_stop_req"}, {31'd0, imem_req}, 32'd0);
                    chk({tag, "_stop_valid"}, {31'd0, instr_valid}, 32'd0);
                    chk({tag, "_stop_pc"}, pc, vecs[i].pc);
                end
                set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end else begin
                chk({tag, "_next_req"}, {31'd0, imem_req}, 32'd1);
                chk({tag, "_next_addr"}, imem_addr, vecs[i].nxt);
            end
        end

        // Reset while a fetch is outstanding, with an ack arriving late.
        ack_delay = 100;
        do_reset();
        @(posedge clk); #1;
        chk("midf_req_up", {31'd0, imem_req}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midf_req_held", {31'd0, imem_req}, 32'd1);
        rst = 1'b1;
        ack_force = 1'b1;
        @(posedge clk); #1;
        chk("midf_req_drop", {31'd0, imem_req}, 32'd0);
        chk("midf_valid", {31'd0, instr_valid}, 32'd0);
        chk("midf_pc", pc, 32'h0);
        chk("midf_trap_clr", {31'd0, trap}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("late_ack_ignored", {31'd0, instr_valid}, 32'd0);
        chk("refetch_req", {31'd0, imem_req}, 32'd1);
        ack_force = 1'b0;
        ack_delay = 0;
        wait_exec("refetch", 32'h0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and program-counter stage, directly upstream of the control unit. Holds the PC and fetches each instruction from instruction memory over a req/ack handshake. Presents the instruction with a one-cycle `instr_valid` strobe. In that same cycle it samples the control unit's branch, JAL, JALR and halt decisions and selects the next PC. Halt is latched here and is terminal until reset.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `branch`  in  1  control unit: conditional branch taken.
- `jal_flag`  in  1  control unit: JAL executing.
- `jalr_flag`  in  1  control unit: JALR executing.
- `halt`  in  1  control unit: HALT opcode executing.
- `imm`  in  32  sign-extended immediate of the current instruction.
- `rs1_data`  in  32  register-file rs1 read value, for JALR.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_ack`  in  1  memory response valid; `imem_rdata` captured on this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  latched instruction.
- `instr_valid`  out  1  one-cycle strobe: `instr` is executing; downstream commits only when high.
- `pc`  out  32  address of `instr`.
- `pc_plus4`  out  32  `pc + 4`, the JAL/JALR link value.
- `halted`  out  1  sticky halt indicator.
- `trap`  out  1  sticky misaligned-target indicator.

## Operation
- The state machine has four states: IDLE, FETCH, EXEC and STOP.
- **IDLE** (entered on reset): next state is FETCH.
- **FETCH**:
  - `imem_req`=1, `imem_addr`=`pc`, both held stable until ack.
  - On `imem_ack`, latch `instr`←`imem_rdata` and go to EXEC.
- **EXEC**:
  - `instr_valid`=1 for exactly this cycle.
  - Control inputs are sampled only in this cycle and are ignored in all other states.
  - Next-PC priority: `halt` > `jalr_flag` > `jal_flag` > `branch` > sequential.
    - halt: PC unchanged, go to STOP, set `halted`.
    - JALR: target = (`rs1_data` + `imm`) & ~32'h1.
    - JAL or branch: target = `pc` + `imm`.
    - Otherwise: target = `pc` + 4.
  - If the selected target has [1:0] ≠ 0: PC unchanged, set `trap`, go to STOP.
  - Otherwise: load `pc`←target and go to FETCH.
- **STOP**:
  - Terminal; only `rst` exits.
  - `imem_req`=0, `instr_valid`=0, `pc` frozen.
- Arithmetic is 32-bit modulo 2^32; wrap-around is not flagged.
- `imem_ack` is ignored outside FETCH.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `instr`=32'h0000_0013 (NOP).
  - `instr_valid`, `imem_req`, `halted`, `trap` all 0.
  - State = IDLE.
- `imem_req` first rises 1 cycle after reset deassertion.
- A combinational ack (ack in the first FETCH cycle) gives a 2-cycle instruction period, FETCH+EXEC. Each wait cycle without ack adds 1 cycle.
- `pc` updates on the clock edge that ends EXEC, so the new `imem_addr` is visible in the next FETCH.
- `pc_plus4` is combinational from `pc`.
- Simultaneous `halt` and `branch`/`jal_flag`/`jalr_flag`: halt wins, `trap` stays 0.
- `rst` asserted in any state, including mid-FETCH with the request outstanding:
  - next cycle is IDLE with reset values and `imem_req`=0;
  - a late ack is ignored.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants (R/I/S/L/B/JAL/JALR/HALT);
  - `NOP_INSTR`;
  - `fetch_state_t` enum.
- Sub-module `next_pc_calc`: combinational priority mux plus target adders and the misalignment check. `fetch_unit` keeps only the state machine and registers.

## Test plan
- Reset release with `RESET_PC`=0 and an always-ack memory → `imem_addr` sequence 0, 4, 8; `instr_valid` pulses every 2nd cycle.
- `imem_ack` delayed 3 cycles at PC=0x10 → `imem_req`/`imem_addr`=0x10 held 4 cycles; `instr_valid` exactly once.
- EXEC at pc=0x20 with `branch`=1, `imm`=-8 → next fetch at 0x18.
- JALR with `rs1_data`=0x101, `imm`=0x4 → next fetch at 0x104; `pc_plus4` observed as old pc+4 during EXEC.
- `halt`=1 with `jal_flag`=1 at pc=0x40:
  - `halted`=1, `pc` stays 0x40;
  - no further `imem_req` for 20 cycles;
  - `rst` restores fetch from `RESET_PC`.
- JAL to pc+0x2 (misaligned) → `trap`=1, STOP; `rst` mid-FETCH drops `imem_req` the next cycle.
